// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: round-robin pointer state,
// port count and the read-return tag.
package dmem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } ptr_state_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on contention the port
// not granted most recently wins. Grant is one-hot or zero.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 256x32 registered-read data memory.
// Defining DMEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority (no pointer FSM).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    logic [NUM_PORTS-1:0] req_v;
    logic [NUM_PORTS-1:0] gnt_v;
    rd_tag_t              tag_q;
    logic                 read_grant;

    // Reset masks requests so no command can leave the block while memory clears.
    assign req_v = reset ? '0 : {req1, req0};

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign gnt_v = req_v[0] ? 2'b01 : {req_v[1], 1'b0};
`else
    ptr_state_t ptr_q;
    ptr_state_t ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= LAST1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_v[0]) begin
            ptr_d = LAST0;
        end else if (gnt_v[1]) begin
            ptr_d = LAST1;
        end
    end

    rr_pick2 u_pick (
        .req  (req_v),
        .last (ptr_q == LAST1),
        .gnt  (gnt_v)
    );
`endif

    assign gnt0 = gnt_v[0];
    assign gnt1 = gnt_v[1];

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (gnt_v[0]) begin
            mem_addr  = 32'(addr0);
            mem_wdata = wdata0;
            mem_write = we0;
            mem_read  = ~we0;
        end else if (gnt_v[1]) begin
            mem_addr  = 32'(addr1);
            mem_wdata = wdata1;
            mem_write = we1;
            mem_read  = ~we1;
        end
    end

    assign read_grant = (gnt_v[0] & ~we0) | (gnt_v[1] & ~we1);

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= '{valid: read_grant, port: gnt_v[1]};
        end
    end

    // Returns are also masked during reset so an in-flight read is dropped.
    assign rvalid0 = tag_q.valid & ~tag_q.port & ~reset;
    assign rvalid1 = tag_q.valid &  tag_q.port & ~reset;
    assign rdata   = (tag_q.valid & ~reset) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256x32
// registered-read memory (loaded with contents = index, words 0-31 cleared on reset).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [256];
    logic        preload = 1'b0;

    int total = 0;
    int bad   = 0;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
        end else if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b1;
            drive(1, 0, 8'd3, '0, 1, 0, 8'd4, '0);
            #1;
            total++;
            if ({gnt1, gnt0} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", {gnt1, gnt0}); end
            total++;
            if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_cmd got=%b want=00", {mem_read, mem_write}); end
            total++;
            if ({rvalid1, rvalid0} !== 2'b00 || rdata !== 32'h0) begin
                bad++; $display("FAIL reset_rd got=%b/%h want=00/00000000", {rvalid1, rvalid0}, rdata);
            end
        end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drive(1, 1, 8'd5, 32'hDEADBEEF, 0, 0, '0, '0);
        #1;
        total++;
        if ({gnt1, gnt0} !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b want=01", {gnt1, gnt0}); end
        total++;
        if ({mem_read, mem_write} !== 2'b01) begin bad++; $display("FAIL wr_cmd got=%b want=01", {mem_read, mem_write}); end
        total++;
        if (mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL wr_bus got=%h/%h want=00000005/deadbeef", mem_addr, mem_wdata);
        end
        @(negedge clk);
        drive(1, 0, 8'd5, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({gnt1, gnt0, mem_read, mem_write} !== 4'b0110) begin
            bad++; $display("FAIL rd_cmd got=%b want=0110", {gnt1, gnt0, mem_read, mem_write});
        end
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid got=%b want=00", {rvalid1, rvalid0}); end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_return got=%b/%h want=01/deadbeef", {rvalid1, rvalid0}, rdata);
        end
    endtask

    task automatic test_read_then_write();
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 0, 8'd7, '0);
        #1;
        total++;
        if ({gnt1, gnt0, mem_read} !== 3'b101 || mem_addr !== 32'd7) begin
            bad++; $display("FAIL p1_rd got=%b/%h want=101/00000007", {gnt1, gnt0, mem_read}, mem_addr);
        end
        @(negedge clk);
        drive(1, 1, 8'd7, 32'h12345678, 0, 0, '0, '0);
        #1;
        total++;
        if ({gnt1, gnt0, mem_write} !== 3'b011) begin bad++; $display("FAIL p0_wr got=%b want=011", {gnt1, gnt0, mem_write}); end
        total++;
        if ({rvalid1, rvalid0} !== 2'b10 || rdata !== 32'd7) begin
            bad++; $display("FAIL old_data got=%b/%h want=10/00000007", {rvalid1, rvalid0}, rdata);
        end
        @(negedge clk);
        drive(1, 0, 8'd7, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL wr_after_rd_rv got=%b want=00", {rvalid1, rvalid0}); end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== 32'h12345678) begin
            bad++; $display("FAIL new_data got=%b/%h want=01/12345678", {rvalid1, rvalid0}, rdata);
        end
    endtask

    task automatic test_contention();
        logic       expp;
        logic       expg;
        logic [1:0] expgnt;
        // lone port-1 read leaves the last-grant pointer at port 1
        @(negedge clk);
        drive(0, 0, '0, '0, 1, 0, 8'd20, '0);
        #1;
        total++;
        if ({gnt1, gnt0} !== 2'b10) begin bad++; $display("FAIL cont_setup got=%b want=10", {gnt1, gnt0}); end
        expp = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c < 6) drive(1, 0, 8'd10, '0, 1, 0, 8'd20, '0);
            else       drive(0, 0, '0, '0, 0, 0, '0, '0);
            #1;
            total++;
            if ({rvalid1, rvalid0} !== (expp ? 2'b10 : 2'b01) || rdata !== (expp ? 32'd20 : 32'd10)) begin
                bad++; $display("FAIL cont_rv c=%0d got=%b/%h want_port=%0d", c, {rvalid1, rvalid0}, rdata, expp);
            end
            if (c < 6) begin
                expg   = FIXED ? 1'b0 : ((c % 2) == 1);
                expgnt = expg ? 2'b10 : 2'b01;
                total++;
                if ({gnt1, gnt0} !== expgnt) begin
                    bad++; $display("FAIL cont_gnt c=%0d got=%b want=%b", c, {gnt1, gnt0}, expgnt);
                end
                expp = expg;
            end
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(0, 0, 8'd9, 32'hFFFF0000, 0, 1, 8'd11, 32'h0000FFFF);
            #1;
            total++;
            if ({gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                bad++; $display("FAIL idle c=%0d got=%b/%h/%h want=000000/0/0", c,
                                {gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write}, mem_addr, mem_wdata);
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        drive(1, 0, 8'd40, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({gnt1, gnt0} !== 2'b01) begin bad++; $display("FAIL inf_gnt got=%b want=01", {gnt1, gnt0}); end
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 8'd40, '0, 1, 0, 8'd41, '0);
        #1;
        total++;
        if ({gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write} !== 6'b0 || rdata !== 32'h0) begin
            bad++; $display("FAIL inf_reset got=%b/%h want=000000/00000000",
                            {gnt1, gnt0, rvalid1, rvalid0, mem_read, mem_write}, rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({gnt1, gnt0} !== 2'b01) begin bad++; $display("FAIL post_rst_gnt got=%b want=01", {gnt1, gnt0}); end
        total++;
        if ({rvalid1, rvalid0} !== 2'b00) begin bad++; $display("FAIL dropped_rv got=%b want=00", {rvalid1, rvalid0}); end
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        total++;
        if ({rvalid1, rvalid0} !== 2'b01 || rdata !== 32'd40) begin
            bad++; $display("FAIL post_rst_rd got=%b/%h want=01/00000028", {rvalid1, rvalid0}, rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        test_reset();
        test_write_read();
        test_read_then_write();
        test_contention();
        test_idle();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
